vetor_para_binario_seq: RTL and testbench
=========================================

Name: vetor_para_binario_seq

Overview:
- Sequential inverse of the Kronecker one-hot encoder: converts a 2**NUM_BITS one-hot vector back to its NUM_BITS-bit index.
- Works by iterative Kronecker factorisation. Each cycle it halves the active segment and resolves one index bit, MSB first, in the same order the encoder builds the vector.
- Sits on the decode side of the one-hot path, with valid/ready handshakes on both sides.
- Flags illegal inputs (zero bits set or several bits set).

Parameters:
- NUM_BITS, 4, index width. Vector width is N = 2**NUM_BITS. Legal range is NUM_BITS >= 1.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input vector valid
- in_ready  output  1  block can accept a vector
- vetor_binario  input  N  one-hot vector; bit k set means index k
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- numero_decimal  output  NUM_BITS  decoded index
- erro  output  1  input was not exactly one-hot

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - out_valid = 0, numero_decimal = 0, erro = 0
  - step counter = 0, segment register = 0
  - in_ready = 0 while rst_n is low, 1 after release.
- in_ready = 1 only in state IDLE (and rst_n high).
- Input handshake: a transfer occurs on the edge where in_valid && in_ready. vetor_binario is copied into an N-bit segment register, step = 0, and state goes to FACTOR. in_valid while not ready is ignored; there is no buffering.
- FACTOR, step i (0..NUM_BITS-1), active width W = 2**(NUM_BITS-i):
  - up = seg[W-1:W/2], lo = seg[W/2-1:0].
  - up != 0 && lo == 0: index bit NUM_BITS-1-i = 1; seg <= up (zero-extended).
  - lo != 0 && up == 0: index bit = 0; seg <= lo.
  - Both zero, or both nonzero: abort. erro <= 1, numero_decimal <= 0, go to DONE.
  - Index bits are shifted into numero_decimal MSB first.
  - After step NUM_BITS-1 resolves: go to DONE with erro = 0.
- Latency, counted from the acceptance edge E0 to the edge that sets out_valid:
  - legal one-hot input: NUM_BITS cycles;
  - all-zero input: 1 cycle (caught at step 0);
  - multi-hot input caught at step j: j+1 cycles. This is the first step where both halves are nonzero.
- DONE:
  - out_valid = 1. numero_decimal and erro are held stable.
  - On the edge where out_valid && out_ready: out_valid <= 0, go to IDLE. in_ready rises the next cycle.
  - out_ready low holds DONE indefinitely.
  - No bypass from DONE to FACTOR. Best throughput is one vector per NUM_BITS+2 cycles.
- numero_decimal and erro change only on the DONE entry edge or on reset. They are not cleared on leaving DONE; they keep their last values while out_valid = 0.
- rst_n asserted in any state, including mid-FACTOR or in DONE: immediate return to reset values. The in-flight vector is discarded and no out_valid is produced for it.
- NUM_BITS = 1: a single step; vector 2'b01 gives 0, 2'b10 gives 1, 2'b00 and 2'b11 give erro.
- All widths are derived from NUM_BITS. The step counter is $clog2(NUM_BITS)+1 bits. There are no 32-bit integer literals in concatenations.

Test Plan:
- Reset mid-operation: accept 16'h0400, drop rst_n after 2 cycles -> out_valid, numero_decimal and erro are 0 immediately; in_ready is 1 after release; no result is emitted.
- NUM_BITS=4, vetor 16'h0001 / 16'h8000 / 16'h0400 -> numero_decimal 0 / 15 / 10 with erro=0; out_valid is set exactly 4 cycles after each acceptance edge.
- vetor 16'h0000 -> erro=1, numero_decimal=0, out_valid 1 cycle after acceptance.
- Multi-hot inputs:
  - 16'h0101 -> erro=1 at latency 1 (step 0).
  - 16'h0003 -> erro=1 at latency 4 (step 3).
  - 16'h0030 -> erro=1 at latency 4.
- Backpressure: after a result, hold out_ready low for 5 cycles while in_valid pulses with new vectors -> outputs stay stable, in_ready stays 0, and the new vectors are not captured. Raising out_ready -> one handshake, then in_ready=1 on the next cycle.
- Round trip: drive the one-hot encoder with 0..15, feed its output with in_valid held high and out_ready held high -> numero_decimal equals the source value every time, erro=0, one result every 6 cycles.

Source files
------------

// File: rtl/vetor_para_binario_seq_if.sv
// Handshake bundle for the one-hot to index decoder: vector input side and result output side.
interface vetor_para_binario_seq_if #(
  parameter int NUM_BITS = 4
);
  localparam int N = 2 ** NUM_BITS;

  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        vetor_binario;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_BITS-1:0] numero_decimal;
  logic                erro;

  modport master (
    output in_valid, vetor_binario, out_ready,
    input  in_ready, out_valid, numero_decimal, erro
  );

  modport slave (
    input  in_valid, vetor_binario, out_ready,
    output in_ready, out_valid, numero_decimal, erro
  );
endinterface

// File: rtl/vetor_para_binario_seq.sv
// Sequential one-hot to index decoder: halves the active segment each cycle, resolving
// one index bit MSB first, and flags vectors that are not exactly one-hot.
module vetor_para_binario_seq #(
  parameter int NUM_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  vetor_para_binario_seq_if.slave   bus
);
  localparam int N      = 2 ** NUM_BITS;
  localparam int STEP_W = $clog2(NUM_BITS) + 1;

  typedef enum logic [1:0] {IDLE, FACTOR, DONE} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        seg_q;
  logic [STEP_W-1:0]   step_q;
  logic [NUM_BITS-1:0] idx_q;
  logic [NUM_BITS-1:0] numero_q;
  logic                erro_q;

  logic [N-1:0]        lo_mask, up_seg, lo_seg;
  logic                take_up, take_lo, bad, last_step;
  logic [NUM_BITS-1:0] idx_next;

  // Upper bits above the active width are always zero, so a plain right shift
  // yields the upper half without masking.
  always_comb begin
    lo_mask = '0;
    up_seg  = '0;
    for (int unsigned k = 0; k < NUM_BITS; k++) begin
      if (step_q == STEP_W'(k)) begin
        lo_mask = '1;
        lo_mask = lo_mask >> (N - (N >> (k + 1)));
        up_seg  = seg_q >> (N >> (k + 1));
      end
    end
    lo_seg = seg_q & lo_mask;
  end

  assign take_up   = (|up_seg) && !(|lo_seg);
  assign take_lo   = (|lo_seg) && !(|up_seg);
  assign bad       = !(take_up || take_lo);
  assign last_step = (step_q == STEP_W'(NUM_BITS - 1));
  assign idx_next  = (idx_q << 1) | NUM_BITS'(take_up);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = FACTOR;
      FACTOR:  if (bad || last_step) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= '0;
      step_q   <= '0;
      idx_q    <= '0;
      numero_q <= '0;
      erro_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            seg_q  <= bus.vetor_binario;
            step_q <= '0;
            idx_q  <= '0;
          end
        end
        FACTOR: begin
          if (bad) begin
            erro_q   <= 1'b1;
            numero_q <= '0;
          end else begin
            seg_q  <= take_up ? up_seg : lo_seg;
            step_q <= step_q + 1'b1;
            idx_q  <= idx_next;
            if (last_step) begin
              numero_q <= idx_next;
              erro_q   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = (state_q == IDLE) && rst_n;
  assign bus.out_valid      = (state_q == DONE);
  assign bus.numero_decimal = numero_q;
  assign bus.erro           = erro_q;
endmodule

// File: tb/tb_vetor_para_binario_seq.sv
// Self-checking bench for vetor_para_binario_seq: directed, randomized, backpressure,
// reset and encoder round-trip scenarios against a bit-position reference model.
module tb_vetor_para_binario_seq;
  localparam int NB = 4;
  localparam int N  = 2 ** NB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  vetor_para_binario_seq_if #(.NUM_BITS(NB)) bus ();

  vetor_para_binario_seq #(.NUM_BITS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: index of the set bit, error unless exactly one bit is set.
  function automatic bit ref_err(input logic [N-1:0] v);
    return $countones(v) != 1;
  endfunction

  function automatic int ref_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Latency: legal -> NB; zero -> 1; multi-hot -> number of common leading index
  // bits of the lowest and highest set positions, plus one.
  function automatic int ref_lat(input logic [N-1:0] v);
    int lo, hi, d, p;
    if (v == '0) return 1;
    lo = -1; hi = -1;
    for (int i = 0; i < N; i++) if (v[i]) begin
      if (lo < 0) lo = i;
      hi = i;
    end
    if (lo == hi) return NB;
    d = lo ^ hi;
    p = 0;
    for (int i = 0; i < NB; i++) if (d[i]) p = i;
    return NB - p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one vector, checks latency/result, then completes the output handshake.
  task automatic run_vec(input logic [N-1:0] v, input string name);
    int lat, wait_c;
    logic [NB-1:0] exp_idx;
    wait_c = 0;
    while (!bus.in_ready && wait_c < 20) begin tick(); wait_c++; end
    bus.vetor_binario = v;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin tick(); lat++; end
    exp_idx = ref_err(v) ? '0 : NB'(ref_idx(v));
    tests_run++;
    if (lat !== ref_lat(v)) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d expected %0d (v=%h)", name, lat, ref_lat(v), v);
    end
    tests_run++;
    if (bus.numero_decimal !== exp_idx || bus.erro !== ref_err(v)) begin
      tests_failed++;
      $display("FAIL %s result: got idx=%0d erro=%b expected idx=%0d erro=%b (v=%h)",
               name, bus.numero_decimal, bus.erro, exp_idx, ref_err(v), v);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b expected 0 1",
               name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.numero_decimal !== '0 || bus.erro !== 1'b0 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: got ov=%b idx=%0d erro=%b ir=%b expected 0 0 0 0",
               bus.out_valid, bus.numero_decimal, bus.erro, bus.in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    run_vec(16'h8000, "pre_reset");
    bus.vetor_binario = 16'h0400;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.numero_decimal !== '0 || bus.erro !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got ov=%b idx=%0d erro=%b expected 0 0 0",
               bus.out_valid, bus.numero_decimal, bus.erro);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_ready: in_ready got %b expected 1", bus.in_ready);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_result: got %0d out_valid cycles expected 0", seen);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] vecs [7];
    vecs = '{16'h0001, 16'h8000, 16'h0400, 16'h0000, 16'h0101, 16'h0003, 16'h0030};
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("directed_%0d", i));
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) v = N'(1) << $urandom_range(N - 1);
      else v = N'($urandom);
      run_vec(v, $sformatf("random_%0d", i));
    end
  endtask

  task automatic test_backpressure();
    logic [NB-1:0] held_idx;
    logic          held_err;
    int            bad, seen;
    bus.vetor_binario = 16'h0200;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    held_idx = bus.numero_decimal;
    held_err = bus.erro;
    tests_run++;
    if (held_idx !== 4'd9 || held_err !== 1'b0 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_result: got ov=%b idx=%0d erro=%b expected 1 9 0",
               bus.out_valid, held_idx, held_err);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      bus.vetor_binario = N'(1) << $urandom_range(N - 1);
      bus.in_valid = (i % 2 == 0);
      tick();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.numero_decimal !== held_idx || bus.erro !== held_err) bad++;
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: got ov=%b ir=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid || !bus.in_ready) seen++;
      tick();
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL bp_no_capture: got %0d busy cycles expected 0", seen);
    end
  endtask

  task automatic test_round_trip();
    int q[$];
    int src, results, cyc, last_res, exp;
    bit acc, res;
    src = 0; results = 0; cyc = 0; last_res = -1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.vetor_binario = N'(1) << src;
    while (results < N && cyc < 400) begin
      acc = bus.in_valid && bus.in_ready;
      res = bus.out_valid;
      if (res) begin
        exp = q.size() > 0 ? q.pop_front() : -1;
        tests_run++;
        if (int'(bus.numero_decimal) != exp || bus.erro !== 1'b0) begin
          tests_failed++;
          $display("FAIL round_trip: got idx=%0d erro=%b expected idx=%0d erro=0",
                   bus.numero_decimal, bus.erro, exp);
        end
        if (last_res >= 0) begin
          tests_run++;
          if (cyc - last_res != NB + 2) begin
            tests_failed++;
            $display("FAIL round_trip_rate: got %0d cycles expected %0d", cyc - last_res, NB + 2);
          end
        end
        last_res = cyc;
        results++;
      end
      tick();
      cyc++;
      if (acc) begin
        q.push_back(src);
        src++;
        if (src >= N) bus.in_valid = 1'b0;
        else bus.vetor_binario = N'(1) << src;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tests_run++;
    if (results != N) begin
      tests_failed++;
      $display("FAIL round_trip_count: got %0d results expected %0d", results, N);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.vetor_binario = '0;
    test_reset();
    test_reset_mid();
    test_directed();
    test_random();
    test_backpressure();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
